// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states, data width.
package riscv_lsu_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge, error decode.
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic              i_we,
   input  logic [2:0]        i_funct3,
   input  logic [1:0]        i_addr,
   input  logic [WORD_W-1:0] i_rdata,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_load,
   output logic [WORD_W-1:0] o_merged,
   output logic              o_misaligned,
   output logic              o_illegal
);

   logic [4:0]  w_sh;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_mis_raw;

   assign w_sh   = {i_addr, 3'b000};
   assign w_byte = i_rdata[w_sh +: 8];
   assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_illegal = 1'b1;
      w_mis_raw = 1'b0;
      case (i_funct3)
         F3_B, F3_H, F3_W: o_illegal = 1'b0;
         F3_BU, F3_HU:     o_illegal = i_we;
         default:          o_illegal = 1'b1;
      endcase
      case (i_funct3)
         F3_H, F3_HU: w_mis_raw = i_addr[0];
         F3_W:        w_mis_raw = |i_addr;
         default:     w_mis_raw = 1'b0;
      endcase
      // an illegal code never also reports misalignment
      o_misaligned = w_mis_raw & ~o_illegal;
   end

   always_comb begin
      o_load = '0;
      case (i_funct3)
         F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_load = {{16{w_half[15]}}, w_half};
         F3_W:    o_load = i_rdata;
         F3_BU:   o_load = {24'h0, w_byte};
         F3_HU:   o_load = {16'h0, w_half};
         default: o_load = '0;
      endcase
   end

   always_comb begin
      o_merged = i_rdata;
      case (i_funct3)
         F3_B: o_merged[w_sh +: 8] = i_wdata[7:0];
         F3_H: begin
            if (i_addr[1]) o_merged[31:16] = i_wdata[15:0];
            else           o_merged[15:0]  = i_wdata[15:0];
         end
         default: o_merged = i_wdata;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit FSM: one request at a time, sub-word stores as read-modify-write.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 5,
   parameter logic [WORD_W-1:0] RESET_RDATA = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic              resp_illegal,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   lsu_state_t        r_state;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [1:0]        r_lane;
   logic [WORD_W-1:0] r_wdata;
   logic              r_req_ready, r_resp_valid, r_misaligned, r_illegal;
   logic              r_mem_re, r_mem_we;
   logic [WORD_W-1:0] r_rdata, r_mem_wdata;
   logic [ADDR_W-1:0] r_mem_addr;

   logic              w_idle, w_we, w_misaligned, w_illegal;
   logic [2:0]        w_funct3;
   logic [1:0]        w_lane;
   logic [WORD_W-1:0] w_load, w_merged;
   logic              w_unused_addr;

   // in IDLE the aligner checks the incoming request, afterwards the latched one
   assign w_idle        = (r_state == IDLE);
   assign w_we          = w_idle ? req_we        : r_we;
   assign w_funct3      = w_idle ? req_funct3    : r_funct3;
   assign w_lane        = w_idle ? req_addr[1:0] : r_lane;
   assign w_unused_addr = ^req_addr[31:ADDR_W+2];

   riscv_lsu_align u_align (
      .i_we         (w_we),
      .i_funct3     (w_funct3),
      .i_addr       (w_lane),
      .i_rdata      (mem_rdata),
      .i_wdata      (r_wdata),
      .o_load       (w_load),
      .o_merged     (w_merged),
      .o_misaligned (w_misaligned),
      .o_illegal    (w_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_we         <= 1'b0;
         r_funct3     <= '0;
         r_lane       <= '0;
         r_wdata      <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_misaligned <= 1'b0;
         r_illegal    <= 1'b0;
         r_mem_re     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_rdata      <= RESET_RDATA;
         r_mem_wdata  <= '0;
         r_mem_addr   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we         <= req_we;
                  r_funct3     <= req_funct3;
                  r_lane       <= req_addr[1:0];
                  r_wdata      <= req_wdata;
                  r_mem_addr   <= req_addr[ADDR_W+1:2];
                  r_misaligned <= w_misaligned;
                  r_illegal    <= w_illegal;
                  r_req_ready  <= 1'b0;
                  if (w_misaligned || w_illegal) begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                     r_rdata      <= '0;
                  end else if (!req_we || req_funct3 != F3_W) begin
                     r_state  <= RD;
                     r_mem_re <= 1'b1;
                  end else begin
                     r_state     <= WR;
                     r_mem_we    <= 1'b1;
                     r_mem_wdata <= req_wdata;
                  end
               end
            end
            RD: begin
               r_mem_re <= 1'b0;
               if (r_we) begin
                  r_state     <= WR;
                  r_mem_we    <= 1'b1;
                  r_mem_wdata <= w_merged;
               end else begin
                  r_state      <= RESP;
                  r_resp_valid <= 1'b1;
                  r_rdata      <= w_load;
               end
            end
            WR: begin
               r_mem_we     <= 1'b0;
               r_state      <= RESP;
               r_resp_valid <= 1'b1;
               r_rdata      <= '0;
            end
            RESP: begin
               if (resp_ready) begin
                  r_state      <= IDLE;
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_rdata      <= RESET_RDATA;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready       = r_req_ready;
   assign resp_valid      = r_resp_valid;
   assign resp_rdata      = r_rdata;
   assign resp_misaligned = r_misaligned;
   assign resp_illegal    = r_illegal;
   assign mem_addr        = r_mem_addr;
   assign mem_re          = r_mem_re;
   assign mem_we          = r_mem_we;
   assign mem_wdata       = r_mem_wdata;

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit directly upstream of the word-addressed data memory.
- Accepts one load/store request from the execute stage per transaction and converts byte/half/word accesses (RV32I funct3) into 32-bit word reads and writes.
- Sub-word stores are done as read-modify-write. Loaded data is returned aligned and sign/zero-extended, with misalignment and illegal-funct3 flags.

Parameters:
- ADDR_W, 5: word-address width driven to the data memory (2^ADDR_W words).
- RESET_RDATA, 32'h0: reset and idle value of resp_rdata.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  LSU can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  response available
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data (0 for stores and errors)
- resp_misaligned  output  1  address not aligned to access size
- resp_illegal  output  1  unsupported funct3 (011, 110, 111, or 100/101 with req_we=1)
- mem_addr  output  ADDR_W  word address = latched addr[ADDR_W+1:2]
- mem_re  output  1  memory read enable
- mem_we  output  1  memory write enable, sampled by memory on posedge clk
- mem_wdata  output  32  word to write
- mem_rdata  input  32  combinational read data for mem_addr

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, resp_misaligned=0, resp_illegal=0.
  - mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_rdata=RESET_RDATA.
  - A reset mid-transaction aborts it. mem_we drops immediately, so no memory write occurs unless the write edge preceded reset.
- mem_re, mem_we and mem_addr are Moore outputs decoded from registered state and latched request. They are glitch-free within a cycle.
- States:
  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata, then go to:
    - RESP with the matching error flag, if illegal or misaligned. No memory access occurs.
    - RD, if a load or a sub-word store.
    - WR, for SW.
  - RD: mem_re=1 for exactly one cycle. Capture mem_rdata at the end of the cycle. A load goes to RESP with extended data; a sub-word store goes to WR with merged data.
  - WR: mem_we=1 for exactly one cycle, mem_wdata = full word (SW) or merged word (SB/SH). Then RESP.
  - RESP: resp_valid=1, req_ready=0. Outputs are held stable until resp_ready=1, then IDLE. There is no request acceptance in RESP (no overlap).
- Alignment and error rules:
  - Misaligned when H/HU has addr[0]=1, or W has addr[1:0]≠0.
  - Illegal takes precedence: if both conditions hold, only resp_illegal=1.
- Extraction:
  - B/BU use byte lane addr[1:0]; H/HU use halfword lane addr[1].
  - B and H sign-extend from bit 7/15; BU and HU zero-extend.
- Merge:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces halfword lane addr[1] with wdata[15:0].
  - All other bits keep the read value.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the memory size.
- Latency from the accept edge to resp_valid:
  - Error: 1 cycle.
  - LW/LB/LH/LBU/LHU and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: at most one transaction per latency + 1 cycles (IDLE re-entry).
- resp_rdata=0 for stores and error responses. Flags are cleared on the next accept.

Decomposition:
- Package riscv_lsu_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The state encoding IDLE/RD/WR/RESP (2 bits).
  - A word-width constant (32).
- One combinational sub-module riscv_lsu_align:
  - Inputs: funct3, addr[1:0], rdata, wdata.
  - Outputs: extended load data, merged store word, misaligned, illegal.
  - The FSM top instantiates it once.

Test Plan:
- Memory word 3 = 32'h8070_F0A5; load LB addr 0x0C → resp_rdata=32'hFFFF_FFA5 two cycles after accept. LBU addr 0x0E → 32'h0000_0070. LH addr 0x0E → 32'hFFFF_8070.
- SB addr 0x0D, wdata 32'h1234_5633, word 3 = 32'h8070_F0A5 → one mem_re cycle, then one mem_we cycle with mem_wdata=32'h8070_33A5. resp_valid 3 cycles after accept.
- SW addr 0x7C (ADDR_W=5), wdata 32'hDEAD_BEEF → mem_addr=31, mem_we for one cycle. Addr 0x80 wraps to mem_addr=0.
- Errors:
  - LW addr 0x02 → resp_misaligned=1, resp_rdata=0, and no mem_re/mem_we in any cycle.
  - funct3=011 → resp_illegal=1 only.
  - SBU (we=1, funct3=100) → resp_illegal=1.
- Hold resp_ready=0 for 4 cycles → resp_valid and data are stable and req_ready=0. A new req_valid is ignored until one cycle after resp_ready=1.
- Assert rst_n=0 asynchronously during the RD state of an SH → all outputs go to reset values within the same cycle, memory is unchanged, and the next request after reset release completes normally.
